// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// Holds the FSM state encoding, access-size codes, the load-type and
// store-mask codes used by the EX/MEM register, and small helpers that
// decode an access into a size and test its natural alignment.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Load-type codes carried in the EX/MEM register.
    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LW  = 3'd2;
    localparam logic [2:0] LT_LD  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;
    localparam logic [2:0] LT_LWU = 3'd6;

    // One-hot store-size masks.
    localparam logic [3:0] WMASK_B = 4'b0001;
    localparam logic [3:0] WMASK_H = 4'b0010;
    localparam logic [3:0] WMASK_W = 4'b0100;
    localparam logic [3:0] WMASK_D = 4'b1000;

    // A malformed mask is treated as a doubleword so it can never
    // produce a partial, silently misplaced write.
    function automatic size_e store_size(input logic [3:0] wmask);
        size_e sz;
        case (wmask)
            WMASK_B: sz = SZ_B;
            WMASK_H: sz = SZ_H;
            WMASK_W: sz = SZ_W;
            default: sz = SZ_D;
        endcase
        return sz;
    endfunction

    function automatic size_e load_size(input logic [2:0] load_type);
        size_e sz;
        case (load_type)
            LT_LB, LT_LBU: sz = SZ_B;
            LT_LH, LT_LHU: sz = SZ_H;
            LT_LW, LT_LWU: sz = SZ_W;
            default:       sz = SZ_D;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input size_e sz, input logic [2:0] off);
        logic ok;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] size_bytes(input size_e sz);
        logic [3:0] n;
        case (sz)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the 64-bit data bus.
// Store side: shifts LSB-justified store data to its byte lane and builds
// the byte strobes. Load side: shifts the bus doubleword down to the
// accessed bytes and sign- or zero-extends them for write-back.
// Ports:
//   st_size/st_off/st_data  -> st_wdata, st_wstrb   (store lane placement)
//   ld_type/ld_off/ld_rdata -> ld_data              (load extract/extend)
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  size_e       st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wstrb,
    input  logic [2:0]  ld_type,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [3:0]  st_lo;
    logic [3:0]  st_hi;
    logic [63:0] ld_shifted;

    assign st_wdata = st_data << {st_off, 3'b000};

    // Lane gi is strobed when it falls inside [off, off+bytes).
    assign st_lo = {1'b0, st_off};
    assign st_hi = {1'b0, st_off} + size_bytes(st_size);

    for (genvar gi = 0; gi < 8; gi++) begin : g_strb
        assign st_wstrb[gi] = (4'(gi) >= st_lo) && (4'(gi) < st_hi);
    end

    assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_shifted;
        case (ld_type)
            LT_LB:   ld_data = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
            LT_LH:   ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            LT_LW:   ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            LT_LBU:  ld_data = {56'd0, ld_shifted[7:0]};
            LT_LHU:  ld_data = {48'd0, ld_shifted[15:0]};
            LT_LWU:  ld_data = {32'd0, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Sequences one load or store from the EX/MEM register onto a
// variable-latency, doubleword-aligned bus (IDLE -> REQ -> WAIT -> DONE),
// stalls the pipeline while the access is outstanding and returns
// aligned, extended load data with a one-cycle o_done pulse.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_mem_ren/i_mem_wen           load / store request (both = store)
//   i_addr, i_wdata               effective address, LSB-justified store data
//   i_mem_wmask, i_load_type      store size (one-hot), load type code
//   o_stall                       combinational pipeline hold
//   o_rdata, o_done               extended load data, completion pulse
//   o_misalign, o_bus_err         misaligned-access pulse, timeout pulse
//   bus_req/we/addr/wdata/wstrb   bus request side, held through REQ
//   bus_gnt, bus_rvalid, bus_rdata bus grant, read data / write ack
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    input  logic [3:0]  i_mem_wmask,
    input  logic [2:0]  i_load_type,
    output logic        o_stall,
    output logic [63:0] o_rdata,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_e      state_reg;
    state_e      state_next;
    logic [15:0] cnt_reg;
    logic [2:0]  ld_type_reg;
    logic [2:0]  ld_off_reg;

    logic        access_req;
    size_e       req_size;
    logic        req_aligned;
    logic        timeout_hit;
    logic [63:0] st_wdata;
    logic [7:0]  st_wstrb;
    logic [63:0] ld_data;

    assign access_req  = i_mem_ren | i_mem_wen;
    assign req_size    = i_mem_wen ? store_size(i_mem_wmask) : load_size(i_load_type);
    assign req_aligned = is_aligned(req_size, i_addr[2:0]);
    assign timeout_hit = (cnt_reg == TIMEOUT_CNT);

    // Store lanes come from the live inputs (captured on REQ entry);
    // load extraction uses the offset/type captured with the request so
    // the returned data does not depend on what the pipeline presents later.
    dmem_lane_align u_lane_align (
        .st_size  (req_size),
        .st_off   (i_addr[2:0]),
        .st_data  (i_wdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_type  (ld_type_reg),
        .ld_off   (ld_off_reg),
        .ld_rdata (bus_rdata),
        .ld_data  (ld_data)
    );

    // Next state and the combinational stall.
    always_comb begin
        state_next = state_reg;
        o_stall    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (access_req && req_aligned) begin
                    state_next = ST_REQ;
                    o_stall    = 1'b1;
                end
            end
            ST_REQ: begin
                o_stall = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (bus_rvalid || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pipeline advances on this edge.
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            ld_type_reg <= '0;
            ld_off_reg  <= '0;
            o_rdata     <= '0;
            o_done      <= 1'b0;
            o_misalign  <= 1'b0;
            o_bus_err   <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_wstrb   <= '0;
        end else begin
            state_reg  <= state_next;
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (access_req) begin
                        if (req_aligned) begin
                            bus_req     <= 1'b1;
                            bus_we      <= i_mem_wen;
                            bus_addr    <= {i_addr[63:3], 3'b000};
                            bus_wdata   <= i_mem_wen ? st_wdata : 64'd0;
                            bus_wstrb   <= i_mem_wen ? st_wstrb : 8'd0;
                            ld_type_reg <= i_load_type;
                            ld_off_reg  <= i_addr[2:0];
                        end else begin
                            o_misalign <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_reg <= '0;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Data wins over a timeout landing in the same cycle.
                    if (bus_rvalid) begin
                        o_done  <= 1'b1;
                        o_rdata <= bus_we ? 64'd0 : ld_data;
                    end else if (timeout_hit) begin
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                        o_rdata   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_DONE: begin
                    cnt_reg <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: one initial block drives a linear
// list of loads/stores, a small bus responder inside run_access answers
// with configurable grant/rvalid delays, and expected completions are
// queued at issue time and popped when o_done is observed.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic [3:0]  i_mem_wmask;
    logic [2:0]  i_load_type;
    logic        o_stall;
    logic [63:0] o_rdata;
    logic        o_done;
    logic        o_misalign;
    logic        o_bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        chk_rdata;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_we;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem_ren   (i_mem_ren),
        .i_mem_wen   (i_mem_wen),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_mem_wmask (i_mem_wmask),
        .i_load_type (i_load_type),
        .o_stall     (o_stall),
        .o_rdata     (o_rdata),
        .o_done      (o_done),
        .o_misalign  (o_misalign),
        .o_bus_err   (o_bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one access, plays the bus, counts stall cycles and checks the
    // completion against the queued expectation. rv_dly < 0 never answers.
    task automatic run_access(
        input string       tag,
        input logic        ren,
        input logic        wen,
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [3:0]  wmask,
        input logic [2:0]  lt,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [63:0] rd,
        input int          exp_stalls,
        input logic        exp_err,
        input logic [63:0] exp_rdata
    );
        exp_t e;
        int   stalls   = 0;
        int   req_cnt  = 0;
        int   wait_cnt = 0;
        bit   granted  = 0;
        bit   in_wait  = 0;
        bit   finished = 0;
        bit   seen_req = 0;

        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.chk_rdata = !wen;
        sb_q.push_back(e);

        i_mem_ren   = ren;
        i_mem_wen   = wen;
        i_addr      = addr;
        i_wdata     = wdata;
        i_mem_wmask = wmask;
        i_load_type = lt;
        bus_rdata   = rd;

        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (in_wait) begin
                if (wait_cnt == rv_dly) begin
                    bus_rvalid = 1'b1;
                    in_wait    = 0;
                end
                wait_cnt++;
            end else if (bus_req && !granted) begin
                if (!seen_req) begin
                    seen_req  = 1;
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                    cap_wstrb = bus_wstrb;
                    cap_we    = bus_we;
                end
                if (req_cnt == gnt_dly) bus_gnt = 1'b1;
                req_cnt++;
            end
            #4;
            if (o_stall) stalls++;
            if (bus_gnt) begin
                granted = 1;
                in_wait = 1;
            end
            if (o_done) begin
                finished = 1;
                total++;
                assert (sb_q.size() != 0) else begin
                    bad++;
                    $error("FAIL %s_sb: observed=o_done expected=no_pending", tag);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    if (e.chk_rdata) check({tag, "_rdata"}, o_rdata, e.rdata);
                    check({tag, "_err"}, {63'd0, o_bus_err}, {63'd0, e.err});
                end
                check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
            end
            tick();
        end
        total++;
        assert (finished) else begin
            bad++;
            $error("FAIL %s_done: observed=no_done expected=done_within_100", tag);
        end
        i_mem_ren  = 1'b0;
        i_mem_wen  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        i_mem_ren   = 1'b0;
        i_mem_wen   = 1'b0;
        i_addr      = '0;
        i_wdata     = '0;
        i_mem_wmask = '0;
        i_load_type = '0;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;

        // Reset state
        repeat (3) tick();
        #4;
        check("rst_stall",    {63'd0, o_stall},    64'd0);
        check("rst_done",     {63'd0, o_done},     64'd0);
        check("rst_misalign", {63'd0, o_misalign}, 64'd0);
        check("rst_bus_err",  {63'd0, o_bus_err},  64'd0);
        check("rst_rdata",    o_rdata,             64'd0);
        check("rst_bus_req",  {63'd0, bus_req},    64'd0);
        check("rst_bus_we",   {63'd0, bus_we},     64'd0);
        check("rst_bus_addr", bus_addr,            64'd0);
        check("rst_bus_wdata", bus_wdata,          64'd0);
        check("rst_bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
        tick();
        rst = 1'b0;

        // Stray gnt/rvalid while idle must not start or finish anything
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        #4;
        check("idle_stray_stall", {63'd0, o_stall}, 64'd0);
        tick();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        #4;
        check("idle_stray_done", {63'd0, o_done},  64'd0);
        check("idle_stray_req",  {63'd0, bus_req}, 64'd0);
        tick();

        // Loads, back-to-back
        run_access("lw_1004",  1, 0, 64'h1004, 64'd0, 4'b0000, 3'd2, 0, 0,
                   64'h8000_0001_DEAD_BEEF, 3, 1'b0, 64'hFFFF_FFFF_8000_0001);
        run_access("lbu_1007", 1, 0, 64'h1007, 64'd0, 4'b0000, 3'd4, 0, 0,
                   64'hF011_2233_4455_6677, 3, 1'b0, 64'h0000_0000_0000_00F0);
        run_access("lb_1007",  1, 0, 64'h1007, 64'd0, 4'b0000, 3'd0, 0, 0,
                   64'hF011_2233_4455_6677, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0);

        // Store half with a delayed grant
        run_access("sh_2002", 0, 1, 64'h2002, 64'h1234, 4'b0010, 3'd0, 2, 0,
                   64'd0, 5, 1'b0, 64'd0);
        check("sh_addr",  cap_addr,            64'h2000);
        check("sh_wstrb", {56'd0, cap_wstrb},  64'h0C);
        check("sh_wdata", cap_wdata,           64'h0000_0000_1234_0000);
        check("sh_we",    {63'd0, cap_we},     64'd1);

        // More load types and latencies
        run_access("lhu_1006", 1, 0, 64'h1006, 64'd0, 4'b0000, 3'd5, 0, 2,
                   64'h8123_0000_0000_0000, 5, 1'b0, 64'h0000_0000_0000_8123);
        run_access("lh_1002",  1, 0, 64'h1002, 64'd0, 4'b0000, 3'd1, 1, 1,
                   64'h0000_0000_8765_0000, 5, 1'b0, 64'hFFFF_FFFF_FFFF_8765);
        run_access("lwu_1004", 1, 0, 64'h1004, 64'd0, 4'b0000, 3'd6, 0, 0,
                   64'h8000_0001_DEAD_BEEF, 3, 1'b0, 64'h0000_0000_8000_0001);
        run_access("ld_1008",  1, 0, 64'h1008, 64'd0, 4'b0000, 3'd3, 0, 0,
                   64'h0123_4567_89AB_CDEF, 3, 1'b0, 64'h0123_4567_89AB_CDEF);

        // Store byte / word / double (ren+wen together is a store)
        run_access("sb_4005", 0, 1, 64'h4005, 64'h0000_0000_0000_00AB, 4'b0001, 3'd0, 0, 0,
                   64'd0, 3, 1'b0, 64'd0);
        check("sb_addr",  cap_addr,           64'h4000);
        check("sb_wstrb", {56'd0, cap_wstrb}, 64'h20);
        check("sb_wdata", cap_wdata,          64'h0000_AB00_0000_0000);
        run_access("sw_4004", 0, 1, 64'h4004, 64'h0000_0000_CAFE_BABE, 4'b0100, 3'd0, 0, 0,
                   64'd0, 3, 1'b0, 64'd0);
        check("sw_wstrb", {56'd0, cap_wstrb}, 64'hF0);
        check("sw_wdata", cap_wdata,          64'hCAFE_BABE_0000_0000);
        run_access("sd_4008", 1, 1, 64'h4008, 64'h1122_3344_5566_7788, 4'b1000, 3'd3, 0, 0,
                   64'd0, 3, 1'b0, 64'd0);
        check("sd_we",    {63'd0, cap_we},    64'd1);
        check("sd_wstrb", {56'd0, cap_wstrb}, 64'hFF);
        check("sd_addr",  cap_addr,           64'h4008);

        // Misaligned store word: no bus cycle, no stall, one misalign pulse
        i_mem_wen   = 1'b1;
        i_addr      = 64'h3002;
        i_wdata     = 64'h5555;
        i_mem_wmask = 4'b0100;
        #4;
        check("mis_stall", {63'd0, o_stall}, 64'd0);
        tick();
        i_mem_wen = 1'b0;
        #4;
        check("mis_pulse", {63'd0, o_misalign}, 64'd1);
        check("mis_req",   {63'd0, bus_req},    64'd0);
        tick();
        #4;
        check("mis_pulse_end", {63'd0, o_misalign}, 64'd0);
        check("mis_req_end",   {63'd0, bus_req},    64'd0);
        tick();

        // Timeout: no rvalid, TIMEOUT=4 -> DONE 5 cycles after entering WAIT
        run_access("ld_timeout", 1, 0, 64'h5000, 64'd0, 4'b0000, 3'd3, 0, -1,
                   64'hFFFF_FFFF_FFFF_FFFF, 2 + TO + 1, 1'b1, 64'd0);
        #4;
        check("to_err_end", {63'd0, o_bus_err}, 64'd0);
        check("to_idle",    {63'd0, o_stall},   64'd0);
        check("to_req",     {63'd0, bus_req},   64'd0);
        tick();

        // Reset while waiting for rvalid; the late rvalid must be dropped
        i_mem_ren   = 1'b1;
        i_addr      = 64'h6000;
        i_load_type = 3'd3;
        bus_rdata   = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        #4;
        check("rstw_req_up", {63'd0, bus_req}, 64'd1);
        #5;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        rst     = 1'b1;
        tick();
        rst        = 1'b0;
        i_mem_ren  = 1'b0;
        bus_rvalid = 1'b1;
        #4;
        check("rstw_req",   {63'd0, bus_req}, 64'd0);
        check("rstw_stall", {63'd0, o_stall}, 64'd0);
        check("rstw_done",  {63'd0, o_done},  64'd0);
        tick();
        bus_rvalid = 1'b0;
        #4;
        check("rstw_done2", {63'd0, o_done},  64'd0);
        check("rstw_rdata", o_rdata,          64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
